// File: rtl/breadboard_sweeper.sv
// Stimulus sequencer for the Breadboard truth-table block: walks {w,x,y,z} through 0..15,
// waits a settle window per vector and reports each sampled f_in. Optional: SWEEP_SIGNATURE_EN.
module breadboard_sweeper #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        mode,
  input  logic        abort,
  input  logic [9:0]  f_in,
  output logic        w,
  output logic        x,
  output logic        y,
  output logic        z,
  output logic        busy,
  output logic        vec_valid,
  output logic [3:0]  vec_index,
  output logic [9:0]  vec_result,
`ifdef SWEEP_SIGNATURE_EN
  output logic        done,
  output logic [15:0] signature
`else
  output logic        done
`endif
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned IDX_W = 4;
  localparam int unsigned F_W   = 10;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             mode_q, mode_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic [IDX_W-1:0] vidx_q, vidx_d;
  logic [F_W-1:0]   vres_q, vres_d;
`ifdef SWEEP_SIGNATURE_EN
  localparam int unsigned SIG_W = 16;
  logic [SIG_W-1:0] sig_q, sig_d;
`endif

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      vidx_q  <= '0;
      vres_q  <= '0;
`ifdef SWEEP_SIGNATURE_EN
      sig_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      vidx_q  <= vidx_d;
      vres_q  <= vres_d;
`ifdef SWEEP_SIGNATURE_EN
      sig_q   <= sig_d;
`endif
    end
  end

  // Next-state and next-output logic; abort overrides everything
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    mode_d  = mode_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    vidx_d  = vidx_q;
    vres_d  = vres_q;
`ifdef SWEEP_SIGNATURE_EN
    sig_d   = sig_q;
`endif
    if (abort) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_SETTLE;
            cnt_d   = '0;
            idx_d   = '0;
            mode_d  = mode;
            busy_d  = 1'b1;
`ifdef SWEEP_SIGNATURE_EN
            sig_d   = '0;
`endif
          end
        end
        ST_SETTLE: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          valid_d = 1'b1;
          vidx_d  = idx_q;
          vres_d  = f_in;
          cnt_d   = '0;
`ifdef SWEEP_SIGNATURE_EN
          sig_d   = sig_q + SIG_W'(f_in);
`endif
          if (idx_q != IDX_LAST) begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_SETTLE;
          end else if (!mode_q) begin
            idx_d   = '0;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            idx_d   = '0;
            state_d = ST_SETTLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = '0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // Stimulus comes straight from the index flops; the index is held at 0 while idle
  assign {w, x, y, z} = idx_q;
  assign busy         = busy_q;
  assign vec_valid    = valid_q;
  assign done         = done_q;
  assign vec_index    = vidx_q;
  assign vec_result   = vres_q;
`ifdef SWEEP_SIGNATURE_EN
  assign signature    = sig_q;
`endif

endmodule

// File: tb/tb_breadboard_sweeper.sv
// Directed bench for breadboard_sweeper: table of sweep scenarios plus hand-written corner sequences.
module tb_breadboard_sweeper;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, mode, abort;
  logic [9:0] f_in;
  logic       w, x, y, z;
  logic       busy, vec_valid, done;
  logic [3:0] vec_index;
  logic [9:0] vec_result;
`ifdef SWEEP_SIGNATURE_EN
  logic [15:0] signature;
`endif

  logic       use_const;
  logic [9:0] f_const;
  logic [9:0] pat;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Breadboard stand-in: loopback of the stimulus with an XOR pattern, or a constant
  always_comb f_in = use_const ? f_const : ({6'b0, w, x, y, z} ^ pat);

  breadboard_sweeper #(.SETTLE_CYCLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode      (mode),
    .abort     (abort),
    .f_in      (f_in),
    .w         (w),
    .x         (x),
    .y         (y),
    .z         (z),
    .busy      (busy),
    .vec_valid (vec_valid),
    .vec_index (vec_index),
    .vec_result(vec_result),
`ifdef SWEEP_SIGNATURE_EN
    .done      (done),
    .signature (signature)
`else
    .done      (done)
`endif
  );

  typedef struct {
    logic       mode;
    logic       hold_start;
    logic [9:0] pat;
    int         cycles;
    int         exp_valids;
    int         exp_dones;
    logic       exp_busy;
  } vec_t;

  vec_t tbl[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_stim(input logic [3:0] val, input int budget);
    for (int i = 0; i < budget; i++) begin
      if ({w, x, y, z} == val) break;
      tick();
    end
    check("wait_stim", 32'({w, x, y, z}), 32'(val));
  endtask

  task automatic abort_cleanup();
    start = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("cleanup_busy", 32'(busy), 32'd0);
    check("cleanup_wxyz", 32'({w, x, y, z}), 32'd0);
  endtask

  // One sweep scenario: start at E0, then check stimulus, samples and timing each cycle
  task automatic run_vec(input vec_t v);
    int valids;
    int dones;
    int exp_idx;
    valids    = 0;
    dones     = 0;
    use_const = 1'b0;
    pat       = v.pat;
    mode      = v.mode;
    start     = 1'b1;
    tick();
    if (!v.hold_start) start = 1'b0;
    check("busy_on", 32'(busy), 32'd1);
    for (int c = 1; c <= v.cycles; c++) begin
      tick();
      exp_idx = (!v.mode && c >= 80) ? 0 : (c / 5) % 16;
      check("stim", 32'({w, x, y, z}), 32'(exp_idx));
      if (vec_valid) begin
        check("vec_index", 32'(vec_index), 32'(valids % 16));
        check("vec_result", 32'(vec_result), 32'(10'(valids % 16) ^ v.pat));
        check("valid_cycle", 32'(c), 32'((valids + 1) * 5));
        valids++;
      end
      if (done) begin
        check("done_cycle", 32'(c), 32'd80);
        dones++;
        start = 1'b0;
      end
    end
    check("n_valids", 32'(valids), 32'(v.exp_valids));
    check("n_dones", 32'(dones), 32'(v.exp_dones));
    check("busy_end", 32'(busy), 32'(v.exp_busy));
    abort_cleanup();
  endtask

  initial begin
    int cnt;
    tbl[0] = '{mode: 1'b0, hold_start: 1'b0, pat: 10'h000, cycles: 90,  exp_valids: 16, exp_dones: 1, exp_busy: 1'b0};
    tbl[1] = '{mode: 1'b0, hold_start: 1'b1, pat: 10'h3F0, cycles: 90,  exp_valids: 16, exp_dones: 1, exp_busy: 1'b0};
    tbl[2] = '{mode: 1'b1, hold_start: 1'b0, pat: 10'h2A5, cycles: 105, exp_valids: 21, exp_dones: 0, exp_busy: 1'b1};
    tbl[3] = '{mode: 1'b1, hold_start: 1'b1, pat: 10'h000, cycles: 85,  exp_valids: 17, exp_dones: 0, exp_busy: 1'b1};

    rst_n = 1'b0; start = 1'b0; mode = 1'b0; abort = 1'b0;
    use_const = 1'b0; f_const = '0; pat = '0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wxyz", 32'({w, x, y, z}), 32'd0);
    check("rst_valid", 32'(vec_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_vec", 32'({vec_index, vec_result}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) run_vec(tbl[i]);

    // Abort in continuous mode while vector 5 is being driven
    pat = '0; mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    wait_stim(4'd5, 40);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_wxyz", 32'({w, x, y, z}), 32'd0);
    check("abort_valid", 32'(vec_valid), 32'd0);
    check("abort_hold_idx", 32'(vec_index), 32'd4);
    cnt = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (vec_valid || done) cnt++;
    end
    check("abort_quiet", 32'(cnt), 32'd0);

    // start and abort together in IDLE
    start = 1'b1; abort = 1'b1; mode = 1'b0;
    tick();
    check("sa_busy1", 32'(busy), 32'd0);
    tick();
    check("sa_busy2", 32'(busy), 32'd0);
    start = 1'b0; abort = 1'b0;

    // Asynchronous reset mid-sweep at index 7, then restart
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_stim(4'd7, 50);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_wxyz", 32'({w, x, y, z}), 32'd0);
    check("mrst_vec", 32'({vec_index, vec_result}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    cnt = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (vec_valid && cnt == 0) begin
        cnt = c;
        check("restart_idx", 32'(vec_index), 32'd0);
      end
    end
    check("restart_cycle", 32'(cnt), 32'd5);
    abort_cleanup();

`ifdef SWEEP_SIGNATURE_EN
    // Signature over a single sweep with constant Breadboard outputs
    for (int s = 0; s < 2; s++) begin
      use_const = 1'b1;
      f_const   = (s == 0) ? 10'h3FF : 10'h000;
      mode      = 1'b0;
      start     = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < 100; c++) begin
        if (done) break;
        tick();
      end
      check("sig_done", 32'(done), 32'd1);
      check("sig_value", 32'(signature), (s == 0) ? 32'h3FF0 : 32'h0);
      tick();
      check("sig_stable", 32'(signature), (s == 0) ? 32'h3FF0 : 32'h0);
    end
    use_const = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
